// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for the EX stage: one quotient bit per cycle,
// sign-corrected {remainder, quotient} held until EX drops start_i.
module div_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam int unsigned          CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [2*DATA_W:0]     r_work, w_work_nxt;
  logic                  r_sign_a, w_sign_a_nxt;
  logic                  r_sign_b, w_sign_b_nxt;
  logic [DATA_W-1:0]     r_abs_b, w_abs_b_nxt;
  logic [2*DATA_W-1:0]   r_result, w_result_nxt;
  logic                  r_ready, w_ready_nxt;

  logic [DATA_W-1:0]     w_abs_a, w_abs_b;
  logic [DATA_W:0]       w_diff;
  logic [DATA_W-1:0]     w_quot, w_rem, w_quot_fix, w_rem_fix;

  // Magnitudes taken only for DIV; 0x80..0 maps onto itself and is then read as unsigned.
  assign w_abs_a = (signed_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_abs_b = (signed_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  assign w_diff     = r_work[2*DATA_W:DATA_W] - {1'b0, r_abs_b};
  assign w_quot     = r_work[DATA_W-1:0];
  assign w_rem      = r_work[2*DATA_W:DATA_W+1];
  assign w_quot_fix = (r_sign_a ^ r_sign_b) ? -w_quot : w_quot;
  assign w_rem_fix  = r_sign_a ? -w_rem : w_rem;

  assign result_o   = r_result;
  assign ready_o    = r_ready;
  assign stallreq_o = start_i & ~r_ready & ~annul_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_work   <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_abs_b  <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_work   <= w_work_nxt;
      r_sign_a <= w_sign_a_nxt;
      r_sign_b <= w_sign_b_nxt;
      r_abs_b  <= w_abs_b_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_work_nxt   = r_work;
    w_sign_a_nxt = r_sign_a;
    w_sign_b_nxt = r_sign_b;
    w_abs_b_nxt  = r_abs_b;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;
    unique case (r_state)
      S_IDLE: begin
        w_ready_nxt  = 1'b0;
        w_result_nxt = '0;
        if (start_i & ~annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = S_BYZERO;
          end else begin
            w_state_nxt  = S_ON;
            w_cnt_nxt    = '0;
            w_sign_a_nxt = signed_i & opdata1_i[DATA_W-1];
            w_sign_b_nxt = signed_i & opdata2_i[DATA_W-1];
            w_abs_b_nxt  = w_abs_b;
            w_work_nxt   = {{DATA_W{1'b0}}, w_abs_a, 1'b0};
          end
        end
      end
      S_BYZERO: begin
        w_result_nxt = '0;
        if (annul_i) begin
          w_state_nxt = S_IDLE;
          w_ready_nxt = 1'b0;
        end else begin
          w_state_nxt = S_END;
          w_ready_nxt = 1'b1;
        end
      end
      S_ON: begin
        if (annul_i) begin
          w_state_nxt  = S_IDLE;
          w_ready_nxt  = 1'b0;
          w_result_nxt = '0;
        end else if (r_cnt != CNT_LAST) begin
          // Trial subtract on the upper half; keep the shifted value when it goes negative.
          if (w_diff[DATA_W]) begin
            w_work_nxt = {r_work[2*DATA_W-1:0], 1'b0};
          end else begin
            w_work_nxt = {w_diff[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};
          end
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_state_nxt  = S_END;
          w_ready_nxt  = 1'b1;
          w_result_nxt = {w_rem_fix, w_quot_fix};
        end
      end
      S_END: begin
        if (annul_i | ~start_i) begin
          w_state_nxt  = S_IDLE;
          w_ready_nxt  = 1'b0;
          w_result_nxt = '0;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_ready_nxt  = 1'b0;
        w_result_nxt = '0;
      end
    endcase
  end

endmodule
